// File: rtl/seq_signed_multiplier.sv
// -----------------------------------------------------------------------------
// seq_signed_multiplier
//   Sequential shift-add multiplier with runtime signed/unsigned mode. The
//   result is in sign-magnitude form: c holds the 2*WIDTH-bit magnitude and
//   neg holds the sign. This form drives the 7-segment display path directly.
//
//   Operation: the operand magnitudes are latched on the accepting edge. One
//   shift-add iteration runs per clock. done rises WIDTH cycles after the
//   accepting edge. c and neg keep their value until the next result replaces
//   them.
//
// Parameters
//   WIDTH        operand width (>= 2); product magnitude is 2*WIDTH bits
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   start        request, level-sampled in IDLE only
//   signed_mode  1 = A/B are two's complement, 0 = unsigned (sampled with start)
//   A, B         multiplicand / multiplier
//   c            product magnitude
//   neg          product sign (1 = negative, never set for a zero product)
//   busy         high while iterating
//   done         high while the result is presented (until start drops)
//
// Configuration
//   SEQ_MULT_EARLY_EXIT_EN  when defined, CALC ends as soon as the shifted
//                           multiplier is zero. There is always at least one
//                           iteration. Results are identical; only latency
//                           changes.
// -----------------------------------------------------------------------------
module seq_signed_multiplier #(
  parameter int WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] c,
  output logic               neg,
  output logic               busy,
  output logic               done
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             sign_q, sign_d;     // sign_a ^ sign_b of the operation
  logic [PW-1:0]    c_q, c_d;
  logic             neg_q, neg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Operand magnitudes. When the sign bit is set, the operand is negated.
  // The value -2^(W-1) maps to 2^(W-1), and that still fits in W unsigned bits.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [PW-1:0]    acc_sum;
  logic [WIDTH-1:0] mplr_next;
  logic             last_iter;

  always_comb begin
    a_neg = signed_mode & A[WIDTH-1];
    b_neg = signed_mode & B[WIDTH-1];
    a_mag = a_neg ? (~A + 1'b1) : A;
    b_mag = b_neg ? (~B + 1'b1) : B;

    // The partial sum cannot overflow: the final magnitude is at most
    // (2^W - 1)^2, which is below 2^(2W).
    acc_sum   = mplr_q[0] ? (acc_q + mcand_q) : acc_q;
    mplr_next = mplr_q >> 1;
`ifdef SEQ_MULT_EARLY_EXIT_EN
    // Once the multiplier has no set bits left, further iterations add nothing.
    last_iter = (count_q == CW'(WIDTH - 1)) || (mplr_next == '0);
`else
    last_iter = (count_q == CW'(WIDTH - 1));
`endif
  end

  // NOTE: every variable written below gets a default first. Without that, any
  // path that skips an assignment would infer a latch.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    count_d = count_q;
    sign_d  = sign_q;
    c_d     = c_q;
    neg_d   = neg_q;
    busy_d  = busy_q;
    done_d  = done_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CALC;
          sign_d  = a_neg ^ b_neg;
          mcand_d = {{WIDTH{1'b0}}, a_mag};
          mplr_d  = b_mag;
          acc_d   = '0;
          count_d = '0;
          busy_d  = 1'b1;
        end
      end

      S_CALC: begin
        acc_d   = acc_sum;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_next;
        count_d = count_q + 1'b1;
        if (last_iter) begin
          state_d = S_DONE;
          c_d     = acc_sum;
          neg_d   = sign_q & (acc_sum != '0);  // no negative zero
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      S_DONE: begin
        // c and neg stay valid in IDLE so the display does not blank.
        if (!start) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // NOTE: registers take their next values with non-blocking assignments.
  // This way all flops update together on the edge, whatever order the
  // statements are in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      count_q <= '0;
      sign_q  <= 1'b0;
      c_q     <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      count_q <= count_d;
      sign_q  <= sign_d;
      c_q     <= c_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign c    = c_q;
  assign neg  = neg_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_seq_signed_multiplier.sv
// -----------------------------------------------------------------------------
// tb_seq_signed_multiplier
//   Self-checking bench for seq_signed_multiplier at WIDTH=6 and WIDTH=8.
//   It uses a table of directed vectors and hand-written sequences for reset,
//   start-hold and operand-change cases. It also runs random operations that
//   are checked against an integer-arithmetic reference model. The expected
//   latency follows the build: with SEQ_MULT_EARLY_EXIT_EN it is set by the
//   multiplier magnitude, otherwise it is WIDTH.
// -----------------------------------------------------------------------------
module tb_seq_signed_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start6, sm6;
  logic [5:0]  a6, b6;
  logic [11:0] c6;
  logic        neg6, busy6, done6;

  logic        start8, sm8;
  logic [7:0]  a8, b8;
  logic [15:0] c8;
  logic        neg8, busy8, done8;

  seq_signed_multiplier #(.WIDTH(6)) dut6 (
    .clk(clk), .rst(rst), .start(start6), .signed_mode(sm6),
    .A(a6), .B(b6), .c(c6), .neg(neg6), .busy(busy6), .done(done6)
  );

  seq_signed_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .A(a8), .B(b8), .c(c8), .neg(neg8), .busy(busy8), .done(done8)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference model: interpret the operands as integers, multiply, and then
  // split the product into magnitude and sign.
  function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                input logic sm, output logic [31:0] mag,
                                output logic n, output int lat);
    longint sa, sb, p, mb, v;
    sa = longint'(a);
    sb = longint'(b);
    if (sm && a[w-1]) sa = sa - (longint'(1) << w);
    if (sm && b[w-1]) sb = sb - (longint'(1) << w);
    p   = sa * sb;
    n   = (p < 0);
    mag = n ? 32'(-p) : 32'(p);
    mb  = (sb < 0) ? -sb : sb;
`ifdef SEQ_MULT_EARLY_EXIT_EN
    // One iteration per multiplier bit up to its highest set bit, minimum one.
    lat = 1;
    v   = mb >> 1;
    while (v != 0) begin
      lat++;
      v = v >> 1;
    end
`else
    v   = mb;
    lat = w;
`endif
  endfunction

  // One WIDTH=6 operation. The task keeps start high for `hold` cycles after
  // done, and can change the operands while CALC is running.
  task automatic op6(input string tag, input logic [5:0] a, input logic [5:0] b,
                     input logic sm, input int hold, input bit scramble,
                     output logic [31:0] c_o, output logic n_o, output int lat);
    logic [11:0] c_keep;
    logic        n_keep;
    @(negedge clk);
    a6 = a; b6 = b; sm6 = sm; start6 = 1'b1;
    @(posedge clk); #1;
    check({tag, "_busy_calc"}, 32'(busy6), 32'd1);
    if (scramble) begin
      @(negedge clk);
      a6 = ~a6; b6 = ~b6; sm6 = ~sm6;
      @(posedge clk); #1;
      lat = 1;
    end else begin
      lat = 0;
    end
    while (!done6 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    c_o = 32'(c6); n_o = neg6;
    c_keep = c6; n_keep = neg6;
    check({tag, "_busy_in_done"}, 32'(busy6), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_done"}, {busy6, done6, neg6 ^ n_keep, 12'(c6 ^ c_keep)}, {3'b010, 12'd0});
    end
    @(negedge clk);
    start6 = 1'b0;
    @(posedge clk); #1;
    check({tag, "_done_drop"}, 32'(done6), 32'd0);
    check({tag, "_c_held_idle"}, {neg6, 12'(c6)}, {n_keep, c_keep});
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                     output logic [31:0] c_o, output logic n_o, output int lat);
    @(negedge clk);
    a8 = a; b8 = b; sm8 = sm; start8 = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!done8 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    c_o = 32'(c8); n_o = neg8;
    @(negedge clk);
    start8 = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [5:0]  a;
    logic [5:0]  b;
    logic        sm;
    logic [31:0] c;
    logic        neg;
    int          lat_early;
  } vec6_t;

  initial begin
    vec6_t       vecs[$];
    logic [31:0] c_got, c_exp;
    logic        n_got, n_exp;
    int          lat_got, lat_exp;

    vecs.push_back('{6'd9,      6'b111001, 1'b1, 32'd63,   1'b1, 3});
    vecs.push_back('{6'b101000, 6'd5,      1'b1, 32'd120,  1'b1, 3});
    vecs.push_back('{6'b101000, 6'd5,      1'b0, 32'd200,  1'b0, 3});
    vecs.push_back('{6'b100000, 6'b100000, 1'b1, 32'd1024, 1'b0, 6});
    vecs.push_back('{6'd0,      6'b111011, 1'b1, 32'd0,    1'b0, 3});
    vecs.push_back('{6'd63,     6'd63,     1'b0, 32'd3969, 1'b0, 6});
    vecs.push_back('{6'd9,      6'd1,      1'b1, 32'd9,    1'b0, 1});
    vecs.push_back('{6'd9,      6'd5,      1'b1, 32'd45,   1'b0, 3});
    vecs.push_back('{6'd9,      6'b100000, 1'b1, 32'd288,  1'b1, 6});
    vecs.push_back('{6'd7,      6'd0,      1'b0, 32'd0,    1'b0, 1});

    rst = 1'b1;
    start6 = 1'b0; sm6 = 1'b0; a6 = '0; b6 = '0;
    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset6_outputs", {13'(c6), neg6, busy6, done6}, 32'd0);
    check("reset8_outputs", {17'(c8), neg8, busy8, done8}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Start is held 15 cycles in total: 1 accept edge, 6 in CALC, 8 in DONE.
    op6("held_start", 6'd9, 6'b111001, 1'b1, 8, 1'b0, c_got, n_got, lat_got);
    check("held_start_c",   c_got, 32'd63);
    check("held_start_neg", 32'(n_got), 32'd1);
    check("held_start_lat", 32'(lat_got),
`ifdef SEQ_MULT_EARLY_EXIT_EN
          32'd3);
`else
          32'd6);
`endif

    foreach (vecs[i]) begin
      op6($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sm, 0, 1'b0, c_got, n_got, lat_got);
`ifdef SEQ_MULT_EARLY_EXIT_EN
      lat_exp = vecs[i].lat_early;
`else
      lat_exp = 6;
`endif
      check($sformatf("vec%0d_c", i),   c_got, vecs[i].c);
      check($sformatf("vec%0d_neg", i), 32'(n_got), 32'(vecs[i].neg));
      check($sformatf("vec%0d_lat", i), 32'(lat_got), 32'(lat_exp));
    end

    // The operands change during CALC; the result must come from the latched values.
    op6("scramble", 6'd21, 6'b111010, 1'b1, 0, 1'b1, c_got, n_got, lat_got);
    check("scramble_c",   c_got, 32'd126);
    check("scramble_neg", 32'(n_got), 32'd1);

    // Reset three cycles into CALC. The previous result (126) must clear at once.
    @(negedge clk);
    a6 = 6'd20; b6 = 6'b111101; sm6 = 1'b1; start6 = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_outputs", {13'(c6), neg6, busy6, done6}, 32'd0);
    @(posedge clk); #1;
    check("rst_beats_start", {busy6, done6}, 32'd0);
    @(negedge clk);
    rst = 1'b0; start6 = 1'b0;
    @(posedge clk); #1;
    check("post_abort_idle", {busy6, done6}, 32'd0);
    op6("after_abort", 6'd20, 6'b111101, 1'b1, 0, 1'b0, c_got, n_got, lat_got);
    check("after_abort_c",   c_got, 32'd60);
    check("after_abort_neg", 32'(n_got), 32'd1);

    // WIDTH=8 corners.
    op8(8'd255, 8'd255, 1'b0, c_got, n_got, lat_got);
    check("w8_unsigned_c",   c_got, 32'd65025);
    check("w8_unsigned_neg", 32'(n_got), 32'd0);
    check("w8_unsigned_lat", 32'(lat_got), 32'd8);
    op8(8'h80, 8'd127, 1'b1, c_got, n_got, lat_got);
    check("w8_signed_c",   c_got, 32'd16256);
    check("w8_signed_neg", 32'(n_got), 32'd1);
    check("w8_signed_lat", 32'(lat_got),
`ifdef SEQ_MULT_EARLY_EXIT_EN
          32'd7);
`else
          32'd8);
`endif

    // Random operations against the reference model.
    for (int k = 0; k < 40; k++) begin
      logic [5:0] ra, rb;
      logic       rs;
      ra = 6'($urandom_range(0, 63));
      rb = 6'($urandom_range(0, 63));
      rs = 1'($urandom_range(0, 1));
      model(6, 32'(ra), 32'(rb), rs, c_exp, n_exp, lat_exp);
      op6($sformatf("rnd%0d", k), ra, rb, rs, k % 3, 1'b0, c_got, n_got, lat_got);
      check($sformatf("rnd%0d_c", k),   c_got, c_exp);
      check($sformatf("rnd%0d_neg", k), 32'(n_got), 32'(n_exp));
      check($sformatf("rnd%0d_lat", k), 32'(lat_got), 32'(lat_exp));
    end
    for (int k = 0; k < 10; k++) begin
      logic [7:0] ra, rb;
      logic       rs;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      model(8, 32'(ra), 32'(rb), rs, c_exp, n_exp, lat_exp);
      op8(ra, rb, rs, c_got, n_got, lat_got);
      check($sformatf("rnd8_%0d_c", k),   c_got, c_exp);
      check($sformatf("rnd8_%0d_neg", k), 32'(n_got), 32'(n_exp));
      check($sformatf("rnd8_%0d_lat", k), 32'(lat_got), 32'(lat_exp));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
